// File: rtl/cfg_update_ctrl.sv
// cfg_update_ctrl: per-thread configuration word bank. A masked write that
// really changes a thread's word drains that thread first and commits the
// word once the thread reports idle, then issues a completion response.
module cfg_update_ctrl #(
  parameter int unsigned          NUM_THREADS = 2,
  parameter int unsigned          CFG_WIDTH   = 32,
  parameter logic [CFG_WIDTH-1:0] RST_VAL     = '0,
  parameter logic [CFG_WIDTH-1:0] WR_MASK     = '1,
  parameter int unsigned          TIMEOUT     = 64,
  parameter int unsigned          TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             wr_valid_i,
  output logic                             wr_ready_o,
  input  logic [TID_W-1:0]                 wr_thread_i,
  input  logic [CFG_WIDTH-1:0]             wr_data_i,
  input  logic [CFG_WIDTH-1:0]             wr_mask_i,
  input  logic [NUM_THREADS-1:0]           idle_i,
  output logic [NUM_THREADS-1:0]           flush_req_o,
  output logic [NUM_THREADS*CFG_WIDTH-1:0] cfg_o,
  output logic [NUM_THREADS-1:0]           cfg_update_o,
  output logic                             done_valid_o,
  output logic                             done_err_o,
  output logic [TID_W-1:0]                 done_thread_o
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, APPLY, DONE} state_e;

  state_e                 state_q, state_d;
  logic [TID_W-1:0]       tid_q, tid_d;
  logic [CFG_WIDTH-1:0]   new_q, new_d;
  logic                   err_q, err_d;
  logic                   applied_q, applied_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CFG_WIDTH-1:0]   cfg_q [NUM_THREADS];
  logic [CFG_WIDTH-1:0]   cfg_d [NUM_THREADS];

  logic                   accept;
  logic                   tid_ok;
  logic [CFG_WIDTH-1:0]   cur_word;
  logic [CFG_WIDTH-1:0]   eff;
  logic [CFG_WIDTH-1:0]   merged;
  logic [NUM_THREADS-1:0] tid_oh;
  logic                   idle_sel;

  // Request decode: pick the addressed word and form the merged candidate;
  // an out-of-range thread reads as zero and is rejected below.
  always_comb begin
    accept   = wr_valid_i && (state_q == IDLE) && !rst_i;
    tid_ok   = 32'(wr_thread_i) < NUM_THREADS;
    cur_word = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if (32'(wr_thread_i) == t) cur_word = cfg_q[t];
    end
    eff    = wr_mask_i & WR_MASK;
    merged = (cur_word & ~eff) | (wr_data_i & eff);
    tid_oh = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      tid_oh[t] = (32'(tid_q) == t);
    end
    idle_sel = |(idle_i & tid_oh);
  end

  // Next-state and output logic of the single-update FSM.
  always_comb begin
    state_d       = state_q;
    tid_d         = tid_q;
    new_d         = new_q;
    err_d         = err_q;
    applied_d     = applied_q;
    cnt_d         = cnt_q;
    cfg_d         = cfg_q;
    wr_ready_o    = (state_q == IDLE) && !rst_i;
    flush_req_o   = '0;
    cfg_update_o  = '0;
    done_valid_o  = 1'b0;
    done_err_o    = 1'b0;
    done_thread_o = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tid_d     = wr_thread_i;
          new_d     = merged;
          cnt_d     = '0;
          applied_d = 1'b0;
          err_d     = 1'b0;
          if (!tid_ok) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (merged == cur_word) begin
            state_d = DONE;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_req_o = tid_oh;
        if (idle_sel) begin
          state_d = APPLY;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      APPLY: begin
        flush_req_o = tid_oh;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
          if (tid_oh[t]) cfg_d[t] = new_q;
        end
        applied_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        done_valid_o  = 1'b1;
        done_err_o    = err_q;
        done_thread_o = tid_q;
        if (applied_q) cfg_update_o = tid_oh;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pack the committed words onto the flat output bus.
  always_comb begin
    cfg_o = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      cfg_o[t*CFG_WIDTH +: CFG_WIDTH] = cfg_q[t];
    end
  end

  // State and word registers with synchronous reset; reset drops any update in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      tid_q     <= '0;
      new_q     <= '0;
      err_q     <= 1'b0;
      applied_q <= 1'b0;
      cnt_q     <= '0;
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        cfg_q[t] <= RST_VAL;
      end
    end else begin
      state_q   <= state_d;
      tid_q     <= tid_d;
      new_q     <= new_d;
      err_q     <= err_d;
      applied_q <= applied_d;
      cnt_q     <= cnt_d;
      cfg_q     <= cfg_d;
    end
  end

endmodule

// File: tb/tb_cfg_update_ctrl.sv
// Table-driven bench for cfg_update_ctrl: two instances (default 2-thread,
// and 3-thread with partial WR_MASK, nonzero RST_VAL, short TIMEOUT).
module tb_cfg_update_ctrl;

  typedef struct {
    int          sel;
    logic [1:0]  tid;
    logic [31:0] data;
    logic [31:0] mask;
    logic [2:0]  idle_acc;
    logic [2:0]  idle_run;
    int          late_at;
    logic [2:0]  idle_late;
    int          lat;
    logic        err;
    logic [2:0]  upd;
    logic [2:0]  flush;
    logic [95:0] cfg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  int          sel = 0;
  logic [1:0]  wr_thread = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] wr_mask = '0;
  logic [2:0]  idle = 3'b111;
  logic        valid_a, valid_b;

  logic        ready_a, done_a, err_a;
  logic [1:0]  flush_a, upd_a;
  logic [63:0] cfg_a;
  logic [0:0]  thr_a;
  logic        ready_b, done_b, err_b;
  logic [2:0]  flush_b, upd_b;
  logic [95:0] cfg_b;
  logic [1:0]  thr_b;

  logic        mx_ready, mx_done, mx_err;
  logic [2:0]  mx_flush, mx_upd;
  logic [95:0] mx_cfg;
  logic [1:0]  mx_thr;

  int n_cmp = 0;
  int n_fail = 0;
  vec_t vt [14];

  always #5 clk = ~clk;

  assign valid_a = wr_valid && (sel == 0);
  assign valid_b = wr_valid && (sel == 1);

  cfg_update_ctrl #(.NUM_THREADS(2), .CFG_WIDTH(32), .TIMEOUT(64)) dut_a (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(valid_a), .wr_ready_o(ready_a),
    .wr_thread_i(wr_thread[0:0]), .wr_data_i(wr_data), .wr_mask_i(wr_mask),
    .idle_i(idle[1:0]), .flush_req_o(flush_a), .cfg_o(cfg_a), .cfg_update_o(upd_a),
    .done_valid_o(done_a), .done_err_o(err_a), .done_thread_o(thr_a));

  cfg_update_ctrl #(.NUM_THREADS(3), .CFG_WIDTH(32), .RST_VAL(32'hC3C3_0000),
                    .WR_MASK(32'h0000_FFFF), .TIMEOUT(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(valid_b), .wr_ready_o(ready_b),
    .wr_thread_i(wr_thread), .wr_data_i(wr_data), .wr_mask_i(wr_mask),
    .idle_i(idle), .flush_req_o(flush_b), .cfg_o(cfg_b), .cfg_update_o(upd_b),
    .done_valid_o(done_b), .done_err_o(err_b), .done_thread_o(thr_b));

  // Route the selected instance onto common observation signals.
  always_comb begin
    if (sel == 0) begin
      mx_ready = ready_a; mx_done = done_a; mx_err = err_a;
      mx_flush = {1'b0, flush_a}; mx_upd = {1'b0, upd_a};
      mx_cfg = {32'h0, cfg_a}; mx_thr = {1'b0, thr_a};
    end else begin
      mx_ready = ready_b; mx_done = done_b; mx_err = err_b;
      mx_flush = flush_b; mx_upd = upd_b;
      mx_cfg = cfg_b; mx_thr = thr_b;
    end
  end

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input int s, input logic [1:0] t, input logic [31:0] d,
                              input logic [31:0] m, input logic [2:0] ia, input logic [2:0] ir,
                              input int la, input logic [2:0] il, input int lat, input logic e,
                              input logic [2:0] u, input logic [2:0] f, input logic [95:0] c);
    vec_t v;
    v.sel = s; v.tid = t; v.data = d; v.mask = m; v.idle_acc = ia; v.idle_run = ir;
    v.late_at = la; v.idle_late = il; v.lat = lat; v.err = e; v.upd = u; v.flush = f;
    v.cfg = c;
    return v;
  endfunction

  task automatic apply(input int idx, input vec_t v);
    int cyc;
    bit got;
    bit flush_bad;
    @(negedge clk);
    sel = v.sel; wr_thread = v.tid; wr_data = v.data; wr_mask = v.mask; idle = v.idle_acc;
    for (int k = 0; k < 20 && !mx_ready; k++) @(negedge clk);
    chk($sformatf("v%0d ready", idx), {95'h0, mx_ready}, 96'h1);
    wr_valid = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    idle = v.idle_run;
    cyc = 1; got = 1'b0; flush_bad = 1'b0;
    while (!got && cyc <= 200) begin
      if (cyc == v.late_at) idle = v.idle_late;
      if (mx_done) begin
        got = 1'b1;
      end else begin
        if (mx_flush !== v.flush || mx_upd !== 3'b000) flush_bad = 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk($sformatf("v%0d latency", idx), 96'(cyc), 96'(v.lat));
    chk($sformatf("v%0d flush_during", idx), {95'h0, flush_bad}, 96'h0);
    chk($sformatf("v%0d err", idx), {95'h0, mx_err}, {95'h0, v.err});
    chk($sformatf("v%0d thread", idx), {94'h0, mx_thr}, {94'h0, v.tid});
    chk($sformatf("v%0d update", idx), {93'h0, mx_upd}, {93'h0, v.upd});
    chk($sformatf("v%0d flush_done", idx), {93'h0, mx_flush}, 96'h0);
    chk($sformatf("v%0d cfg", idx), mx_cfg, v.cfg);
    @(posedge clk); #1;
    chk($sformatf("v%0d after", idx), {91'h0, mx_done, mx_upd, mx_ready}, 96'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(0, 2'd1, 32'hA5, 32'hFF, 3'b111, 3'b111, 0, 3'b111, 3, 1'b0, 3'b010, 3'b010,
                {32'h0, 32'h0000_00A5, 32'h0});
    vt[1]  = mk(0, 2'd1, 32'hA5, 32'hFF, 3'b111, 3'b111, 0, 3'b111, 1, 1'b0, 3'b000, 3'b000,
                {32'h0, 32'h0000_00A5, 32'h0});
    vt[2]  = mk(0, 2'd0, 32'h1234_5678, 32'hFFFF_0000, 3'b111, 3'b111, 0, 3'b111, 3, 1'b0, 3'b001,
                3'b001, {32'h0, 32'h0000_00A5, 32'h1234_0000});
    vt[3]  = mk(0, 2'd1, 32'hFFFF_FFFF, 32'h0, 3'b111, 3'b111, 0, 3'b111, 1, 1'b0, 3'b000, 3'b000,
                {32'h0, 32'h0000_00A5, 32'h1234_0000});
    vt[4]  = mk(0, 2'd1, 32'h0000_FF00, 32'h0000_FF0F, 3'b111, 3'b111, 0, 3'b111, 3, 1'b0, 3'b010,
                3'b010, {32'h0, 32'h0000_FFA0, 32'h1234_0000});
    vt[5]  = mk(0, 2'd0, 32'h1, 32'h1, 3'b110, 3'b110, 0, 3'b110, 65, 1'b1, 3'b000, 3'b001,
                {32'h0, 32'h0000_FFA0, 32'h1234_0000});
    vt[6]  = mk(0, 2'd0, 32'h0, 32'hFFFF_FFFF, 3'b111, 3'b111, 0, 3'b111, 3, 1'b0, 3'b001, 3'b001,
                {32'h0, 32'h0000_FFA0, 32'h0});
    vt[7]  = mk(1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 3'b111, 0, 3'b111, 3, 1'b0, 3'b001,
                3'b001, {32'hC3C3_0000, 32'hC3C3_0000, 32'hC3C3_FFFF});
    vt[8]  = mk(1, 2'd3, 32'h1, 32'h1, 3'b111, 3'b111, 0, 3'b111, 1, 1'b1, 3'b000, 3'b000,
                {32'hC3C3_0000, 32'hC3C3_0000, 32'hC3C3_FFFF});
    vt[9]  = mk(1, 2'd2, 32'h0000_FFFF, 32'hFFFF_0000, 3'b111, 3'b111, 0, 3'b111, 1, 1'b0, 3'b000,
                3'b000, {32'hC3C3_0000, 32'hC3C3_0000, 32'hC3C3_FFFF});
    vt[10] = mk(1, 2'd2, 32'h1, 32'h1, 3'b111, 3'b011, 0, 3'b011, 5, 1'b1, 3'b000, 3'b100,
                {32'hC3C3_0000, 32'hC3C3_0000, 32'hC3C3_FFFF});
    vt[11] = mk(1, 2'd1, 32'h0000_1234, 32'h0000_FFFF, 3'b101, 3'b101, 3, 3'b111, 5, 1'b0, 3'b010,
                3'b010, {32'hC3C3_0000, 32'hC3C3_1234, 32'hC3C3_FFFF});
    vt[12] = mk(1, 2'd2, 32'h0000_BEEF, 32'hFFFF_FFFF, 3'b111, 3'b011, 4, 3'b111, 6, 1'b0, 3'b100,
                3'b100, {32'hC3C3_BEEF, 32'hC3C3_1234, 32'hC3C3_FFFF});
    vt[13] = mk(0, 2'd0, 32'hF0, 32'hFF, 3'b111, 3'b111, 0, 3'b111, 3, 1'b0, 3'b001, 3'b001,
                {32'h0, 32'h0, 32'h0000_00F0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready_held_low", {94'h0, ready_a, ready_b}, 96'h0);
    rst = 1'b0;
    #1;
    chk("rst cfg_a", {32'h0, cfg_a}, 96'h0);
    chk("rst cfg_b", cfg_b, {3{32'hC3C3_0000}});
    chk("rst outs_a", {89'h0, flush_a, upd_a, done_a, err_a, thr_a}, 96'h0);
    chk("rst outs_b", {86'h0, flush_b, upd_b, done_b, err_b, thr_b}, 96'h0);
    chk("rst ready_after", {94'h0, ready_a, ready_b}, 96'h3);

    for (int i = 0; i < 13; i++) apply(i, vt[i]);

    // Reset arriving while a thread-0 update is waiting for drain.
    @(negedge clk);
    sel = 0; wr_thread = 2'd0; wr_data = 32'hF0; wr_mask = 32'hFF; idle = 3'b110;
    wr_valid = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    chk("mid flush_before", {93'h0, mx_flush}, 96'h1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid ready_in_reset", {95'h0, mx_ready}, 96'h0);
    @(posedge clk); #1;
    chk("mid flush", {93'h0, mx_flush}, 96'h0);
    chk("mid cfg_a", mx_cfg, 96'h0);
    chk("mid done", {92'h0, mx_done, mx_upd}, 96'h0);
    chk("mid cfg_b", cfg_b, {3{32'hC3C3_0000}});
    @(posedge clk); #1;
    chk("mid done_hold", {95'h0, mx_done}, 96'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid ready_after", {95'h0, mx_ready}, 96'h1);
    apply(13, vt[13]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
